// File: rtl/pc_predict_ctrl.sv
// pc_predict_ctrl
//   This block owns the registered fetch PC for the 16-bit RISC core.
//   - Arbitrates redirect requests from NREQ resolving stages. The oldest
//     stage, which has the highest index, wins.
//   - Generates the per-pipeline-register flush vector and the IF stall.
//   - Optionally predicts taken branches at fetch. It does this with a tagged,
//     direct-mapped BHT of 2-bit counters.
//
// Build option:
//   PC_BHT_EN  defined   -> BHT storage and prediction are built.
//              undefined -> no BHT. pred_taken is 0 and upd_* are ignored.
//
// Ports:
//   clk, rst_n   core clock (rising edge), async active-low reset
//   req_vld      per-source redirect request (0 = ID, NREQ-1 = oldest)
//   req_tgt      redirect targets, source i at [i*AW +: AW]
//   hold_req     load-use / structural hold from the hazard logic
//   upd_vld      branch resolution update strobe
//   upd_pc       PC of the resolved branch
//   upd_taken    resolved outcome
//   upd_tgt      resolved taken target
//   pc           registered fetch PC
//   pred_taken   current fetch PC predicted taken
//   flush        flush[j] clears the pipeline register after stage j
//   stall        freeze IF and IF/ID this cycle
//   redir        a redirect was accepted this cycle
module pc_predict_ctrl #(
    parameter int              AW        = 16,
    parameter int              NREQ      = 4,
    parameter int              BHT_DEPTH = 8,
    parameter logic [AW-1:0]   RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*AW-1:0]   req_tgt,
    input  logic                 hold_req,
    input  logic                 upd_vld,
    input  logic [AW-1:0]        upd_pc,
    input  logic                 upd_taken,
    input  logic [AW-1:0]        upd_tgt,
    output logic [AW-1:0]        pc,
    output logic                 pred_taken,
    output logic [NREQ-1:0]      flush,
    output logic                 stall,
    output logic                 redir
);

    logic             anyReq;
    logic [NREQ-1:0]  flushVec;
    logic [AW-1:0]    winTgt;
    logic [AW-1:0]    nextPc;
    logic             predRaw;
    logic [AW-1:0]    predTgt;

    assign anyReq = |req_vld;

    // flush[j] is set when any source at index >= j requests.
    // The winner's target comes from the highest requesting index. The
    // ascending loop lets later (older) sources overwrite earlier ones, so
    // slices of non-requesting sources never reach the PC.
    always_comb begin
        flushVec = '0;
        winTgt   = '0;
        for (int j = 0; j < NREQ; j++) begin
            flushVec[j] = |(req_vld >> j);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_vld[i]) winTgt = req_tgt[i*AW +: AW];
        end
    end

    // These outputs are forced quiet while reset is held.
    assign redir      = rst_n & anyReq;
    assign flush      = rst_n ? flushVec : '0;
    assign stall      = rst_n & hold_req & ~anyReq;
    assign pred_taken = rst_n & predRaw;

`ifdef PC_BHT_EN
    localparam int IW = $clog2(BHT_DEPTH);
    localparam int TW = AW - IW;

    logic            bhtVld [BHT_DEPTH];
    logic [TW-1:0]   bhtTag [BHT_DEPTH];
    logic [AW-1:0]   bhtTgt [BHT_DEPTH];
    logic [1:0]      bhtCtr [BHT_DEPTH];

    logic [IW-1:0]   lkIdx;
    logic [IW-1:0]   updIdx;
    logic            lkHit;
    logic            updHit;

    // The lookup reads the registered table. A same-cycle update to the same
    // index therefore becomes visible only on the following cycle.
    assign lkIdx   = pc[IW-1:0];
    assign lkHit   = bhtVld[lkIdx] && (bhtTag[lkIdx] == pc[AW-1:IW]);
    assign predRaw = lkHit && bhtCtr[lkIdx][1];
    assign predTgt = bhtTgt[lkIdx];

    assign updIdx  = upd_pc[IW-1:0];
    assign updHit  = bhtVld[updIdx] && (bhtTag[updIdx] == upd_pc[AW-1:IW]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < BHT_DEPTH; e++) begin
                bhtVld[e] <= 1'b0;
                bhtTag[e] <= '0;
                bhtTgt[e] <= '0;
                bhtCtr[e] <= 2'd0;
            end
        end else if (upd_vld) begin
            if (updHit) begin
                if (upd_taken) begin
                    if (bhtCtr[updIdx] != 2'd3) bhtCtr[updIdx] <= bhtCtr[updIdx] + 2'd1;
                    bhtTgt[updIdx] <= upd_tgt;
                end else if (bhtCtr[updIdx] != 2'd0) begin
                    bhtCtr[updIdx] <= bhtCtr[updIdx] - 2'd1;
                end
            end else if (upd_taken) begin
                // A taken branch that misses allocates the entry, or replaces
                // the aliasing one, and starts it weakly taken.
                bhtVld[updIdx] <= 1'b1;
                bhtTag[updIdx] <= upd_pc[AW-1:IW];
                bhtTgt[updIdx] <= upd_tgt;
                bhtCtr[updIdx] <= 2'd2;
            end
        end
    end
`else
    logic unusedUpd;
    assign unusedUpd = ^{upd_vld, upd_pc, upd_taken, upd_tgt};
    assign predRaw   = 1'b0;
    assign predTgt   = '0;
`endif

    // Next-PC priority, highest first: redirect, hold, prediction, sequential.
    always_comb begin
        nextPc = pc + AW'(1);
        if (anyReq)        nextPc = winTgt;
        else if (hold_req) nextPc = pc;
        else if (predRaw)  nextPc = predTgt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= nextPc;
    end

endmodule

// File: tb/tb_pc_predict_ctrl.sv
module tb_pc_predict_ctrl;

`ifdef PC_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_vld;
    logic [63:0]  req_tgt;
    logic         hold_req;
    logic         upd_vld;
    logic [15:0]  upd_pc;
    logic         upd_taken;
    logic [15:0]  upd_tgt;
    logic [15:0]  pc;
    logic         pred_taken;
    logic [3:0]   flush;
    logic         stall;
    logic         redir;

    int vecs = 0;
    int errs = 0;
    logic [15:0] pcQ[$];

    pc_predict_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_tgt(req_tgt),
        .hold_req(hold_req), .upd_vld(upd_vld), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_tgt(upd_tgt), .pc(pc),
        .pred_taken(pred_taken), .flush(flush), .stall(stall), .redir(redir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: the PC registered at each rising edge.
    always @(posedge clk) begin
        #1;
        if (pcQ.size() > 0) chk("pc", {16'h0, pc}, {16'h0, pcQ.pop_front()});
    end

    // Targets for slot 'slot'; every other slice carries random junk.
    function automatic logic [63:0] mkTgt(input int slot, input logic [15:0] t);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[slot*16 +: 16] = t;
        return v;
    endfunction

    // Called at a falling edge. Drives one cycle, checks the combinational
    // outputs, queues the expected next PC, then returns at the next falling edge.
    task automatic cyc(input logic [3:0] rv, input logic [63:0] tg, input logic hd,
                       input logic uv, input logic [15:0] up, input logic ut,
                       input logic [15:0] utg, input logic [3:0] eF,
                       input logic eS, input logic eP, input logic [15:0] eN);
        req_vld = rv; req_tgt = tg; hold_req = hd;
        upd_vld = uv; upd_pc = up; upd_taken = ut; upd_tgt = utg;
        #1;
        chk("flush", {28'h0, flush}, {28'h0, eF});
        chk("stall", {31'h0, stall}, {31'h0, eS});
        chk("redir", {31'h0, redir}, {31'h0, (rv != 4'b0)});
        chk("pred",  {31'h0, pred_taken}, {31'h0, eP});
        pcQ.push_back(eN);
        @(negedge clk);
    endtask

    task automatic idle(input logic eP, input logic [15:0] eN);
        cyc(4'b0, 64'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 4'b0, 1'b0, eP, eN);
    endtask

    task automatic rd(input int slot, input logic [15:0] t, input logic [3:0] eF,
                      input logic uv, input logic [15:0] up, input logic ut,
                      input logic [15:0] utg);
        cyc(4'b1 << slot, mkTgt(slot, t), 1'b0, uv, up, ut, utg, eF, 1'b0, 1'b0, t);
    endtask

    initial begin
        logic [63:0] tg;
        rst_n = 1'b0; req_vld = '0; req_tgt = '0; hold_req = 1'b0;
        upd_vld = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_tgt = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_flush", {28'h0, flush}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_redir", {31'h0, redir}, 32'h0);
        chk("rst_pred", {31'h0, pred_taken}, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch from the reset PC.
        idle(1'b0, 16'h0001);
        idle(1'b0, 16'h0002);
        idle(1'b0, 16'h0003);

        // Two requesters, with hold raised in the same cycle. The oldest
        // requester wins and the redirect overrides the hold.
        tg = mkTgt(2, 16'h0040);
        tg[15:0] = 16'h0080;
        cyc(4'b0101, tg, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 4'b0111, 1'b0, 1'b0, 16'h0040);
        rd(1, 16'h0010, 4'b0011, 1'b0, 16'h0, 1'b0, 16'h0);

        // Hold for three cycles, then release.
        for (int h = 0; h < 3; h++)
            cyc(4'b0, 64'h0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 4'b0, 1'b1, 1'b0, 16'h0010);
        idle(1'b0, 16'h0011);
        idle(1'b0, 16'h0012);

        // Taken update for 0x13. Only the BHT build predicts it.
        cyc(4'b0, 64'h0, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0100, 4'b0, 1'b0, 1'b0, 16'h0013);
        idle(BHT, BHT ? 16'h0100 : 16'h0014);

        if (BHT) begin
            // Two not-taken updates bring the counter down to 0.
            cyc(4'b0, 64'h0, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0, 4'b0, 1'b0, 1'b0, 16'h0101);
            cyc(4'b0, 64'h0, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0, 4'b0, 1'b0, 1'b0, 16'h0102);
            rd(0, 16'h0013, 4'b0001, 1'b0, 16'h0, 1'b0, 16'h0);
            idle(1'b0, 16'h0014);
            // An alias at the same index replaces the entry.
            cyc(4'b0, 64'h0, 1'b0, 1'b1, 16'h001B, 1'b1, 16'h0300, 4'b0, 1'b0, 1'b0, 16'h0015);
            rd(2, 16'h0013, 4'b0111, 1'b0, 16'h0, 1'b0, 16'h0);
            idle(1'b0, 16'h0014);
            rd(3, 16'h001B, 4'b1111, 1'b0, 16'h0, 1'b0, 16'h0);
            // Same-cycle update at the fetch index: the old prediction is used.
            cyc(4'b0, 64'h0, 1'b0, 1'b1, 16'h001B, 1'b0, 16'h0, 4'b0, 1'b0, 1'b1, 16'h0300);
            // An update during a redirect is still applied (ctr 1 -> 2, new target).
            rd(1, 16'h001B, 4'b0011, 1'b1, 16'h001B, 1'b1, 16'h0400);
            idle(1'b1, 16'h0400);
            // An update during a stall is still applied (ctr 2 -> 1).
            cyc(4'b0, 64'h0, 1'b1, 1'b1, 16'h001B, 1'b0, 16'h0, 4'b0, 1'b1, 1'b0, 16'h0400);
            rd(0, 16'h001B, 4'b0001, 1'b0, 16'h0, 1'b0, 16'h0);
            idle(1'b0, 16'h001C);
            // Re-arm the entry so the reset check below can see it cleared.
            cyc(4'b0, 64'h0, 1'b0, 1'b1, 16'h001B, 1'b1, 16'h0500, 4'b0, 1'b0, 1'b0, 16'h001D);
        end

        // Sequential increment wraps at the top of the address space.
        rd(3, 16'hFFFF, 4'b1111, 1'b0, 16'h0, 1'b0, 16'h0);
        idle(1'b0, 16'h0000);
        idle(1'b0, 16'h0001);

        // Reset asserted in the middle of a redirect.
        req_vld = 4'b1000; req_tgt = mkTgt(3, 16'h1234);
        #1;
        chk("mid_redir", {31'h0, redir}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", {16'h0, pc}, 32'h0);
        chk("mid_rst_redir", {31'h0, redir}, 32'h0);
        chk("mid_rst_flush", {28'h0, flush}, 32'h0);
        @(posedge clk); #1;
        chk("held_rst_pc", {16'h0, pc}, 32'h0);
        @(negedge clk);
        req_vld = '0;
        rst_n = 1'b1;
        idle(1'b0, 16'h0001);
        rd(0, 16'h001B, 4'b0001, 1'b0, 16'h0, 1'b0, 16'h0);
        idle(1'b0, 16'h001C);

        @(posedge clk); #2;
        chk("drain", pcQ.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
